instruction_fetch_unit: RTL and testbench

- Upstream stage that feeds the core with instructions.
- Holds a loadable program memory, a program counter and a fetch state machine.
- Issues one instruction per accepted start/busy handshake and drains the core at program end.
- Reports done, total cycle count and issued-instruction count; replaces ad-hoc bench-side sequencing.

---
 rtl/instruction_fetch_unit_pkg.sv | 18 +
 rtl/instruction_fetch_unit_program_memory.sv | 41 ++++
 rtl/instruction_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   INSTRUCTION_WIDTH : default instruction word width
//   DATA_WIDTH        : default data word width
//   fetch_state_t     : fetch state machine encoding
package instruction_fetch_unit_pkg;

    localparam int INSTRUCTION_WIDTH = 32;
    localparam int DATA_WIDTH        = 32;

    typedef enum logic [2:0] {
        FETCH_IDLE  = 3'd0,
        FETCH_FETCH = 3'd1,
        FETCH_ISSUE = 3'd2,
        FETCH_DRAIN = 3'd3,
        FETCH_DONE  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_program_memory.sv
// Program memory: single write port, synchronous read with one-cycle latency.
//   clk    : clock
//   reset  : async active-high, clears only the read-data register
//   we     : write strobe
//   waddr  : write address
//   wdata  : write data
//   re     : read enable; rdata holds its value while low
//   raddr  : read address
//   rdata  : registered read data
module program_memory #(
    parameter int INSTR_WIDTH = 32,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [ADDR_WIDTH-1:0]  waddr,
    input  logic [INSTR_WIDTH-1:0] wdata,
    input  logic                   re,
    input  logic [ADDR_WIDTH-1:0]  raddr,
    output logic [INSTR_WIDTH-1:0] rdata
);

    logic [INSTR_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: loadable program memory, program counter and fetch
// FSM that issues one instruction per start/~coreBusy handshake, then drains
// the core and reports done.
//   clk, reset      : clock, async active-high reset (memory kept)
//   loadEnable      : program memory write strobe (IDLE/DONE only)
//   loadAddr/Data   : write address / data
//   progLength      : instructions to run, sampled on run, clamped to depth
//   run             : start-of-program pulse (IDLE/DONE only)
//   coreBusy        : core busy flag
//   instructionIn   : instruction presented to the core
//   start           : issue strobe, combinational on coreBusy
//   done            : program complete and core idle
//   programCounter  : address of the presented instruction
//   cycleCount      : saturating count of FETCH/ISSUE/DRAIN cycles
//   issueCount      : accepted issues
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int INSTR_WIDTH = INSTRUCTION_WIDTH,
    parameter int ADDR_WIDTH  = 8,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   loadEnable,
    input  logic [ADDR_WIDTH-1:0]  loadAddr,
    input  logic [INSTR_WIDTH-1:0] loadData,
    input  logic [ADDR_WIDTH:0]    progLength,
    input  logic                   run,
    input  logic                   coreBusy,
    output logic [INSTR_WIDTH-1:0] instructionIn,
    output logic                   start,
    output logic                   done,
    output logic [ADDR_WIDTH-1:0]  programCounter,
    output logic [CNT_WIDTH-1:0]   cycleCount,
    output logic [CNT_WIDTH-1:0]   issueCount
);

    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    fetch_state_t state, state_next;

    logic [ADDR_WIDTH:0]   endCount;
    logic [ADDR_WIDTH:0]   len_clamped;
    logic                  launch;
    logic                  accept;
    logic                  last_issue;
    logic                  counting;
    logic                  mem_we;
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_raddr;

    assign len_clamped = (progLength > MAX_LEN) ? MAX_LEN : progLength;
    assign launch      = run && ((state == FETCH_IDLE) || (state == FETCH_DONE));
    assign accept      = start;
    assign last_issue  = ((issueCount + CNT_WIDTH'(1)) == CNT_WIDTH'(endCount));
    assign counting    = (state == FETCH_FETCH) || (state == FETCH_ISSUE) ||
                         (state == FETCH_DRAIN);
    assign mem_we      = loadEnable && ((state == FETCH_IDLE) || (state == FETCH_DONE));

    // Read the next address on a non-final accept so the registered data
    // always matches mem[programCounter]; on the final accept nothing is
    // read, keeping instructionIn stable through DRAIN/DONE.
    assign mem_re    = (state == FETCH_FETCH) || (accept && !last_issue);
    assign mem_raddr = accept ? (programCounter + ADDR_WIDTH'(1)) : programCounter;

    program_memory #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_program_memory (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .waddr (loadAddr),
        .wdata (loadData),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (instructionIn)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            FETCH_IDLE, FETCH_DONE: begin
                if (run) begin
                    state_next = (len_clamped == '0) ? FETCH_DRAIN : FETCH_FETCH;
                end
            end
            FETCH_FETCH: state_next = FETCH_ISSUE;
            FETCH_ISSUE: begin
                if (accept && last_issue) begin
                    state_next = FETCH_DRAIN;
                end
            end
            FETCH_DRAIN: begin
                if (!coreBusy) begin
                    state_next = FETCH_DONE;
                end
            end
            default: state_next = FETCH_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        start = 1'b0;
        done  = 1'b0;
        case (state)
            FETCH_ISSUE: start = !coreBusy;
            FETCH_DONE:  done  = 1'b1;
            default: ;
        endcase
    end

    // Program counter, end count and counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            programCounter <= '0;
            endCount       <= '0;
            cycleCount     <= '0;
            issueCount     <= '0;
        end else if (launch) begin
            programCounter <= '0;
            endCount       <= len_clamped;
            cycleCount     <= '0;
            issueCount     <= '0;
        end else begin
            if (counting && (cycleCount != '1)) begin
                cycleCount <= cycleCount + CNT_WIDTH'(1);
            end
            if (accept) begin
                issueCount <= issueCount + CNT_WIDTH'(1);
                if (!last_issue) begin
                    programCounter <= programCounter + ADDR_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        loadEnable;
    logic [7:0]  loadAddr;
    logic [31:0] loadData;
    logic [8:0]  progLength;
    logic        run;
    logic        coreBusy;
    logic [31:0] instructionIn;
    logic        start;
    logic        done;
    logic [7:0]  programCounter;
    logic [31:0] cycleCount;
    logic [31:0] issueCount;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] model_mem [256];
    bit          busy_plan [1024];

    instruction_fetch_unit #(
        .INSTR_WIDTH (32),
        .ADDR_WIDTH  (8),
        .CNT_WIDTH   (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .loadEnable     (loadEnable),
        .loadAddr       (loadAddr),
        .loadData       (loadData),
        .progLength     (progLength),
        .run            (run),
        .coreBusy       (coreBusy),
        .instructionIn  (instructionIn),
        .start          (start),
        .done           (done),
        .programCounter (programCounter),
        .cycleCount     (cycleCount),
        .issueCount     (issueCount)
    );

    always #5 clk = ~clk;

    // Caller guarantees the unit is in IDLE or DONE, so the write is honoured.
    task automatic load_word(input int a, input logic [31:0] d);
        loadEnable = 1'b1;
        loadAddr   = a[7:0];
        loadData   = d;
        @(posedge clk); #1;
        loadEnable = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic clear_busy();
        for (int i = 0; i < 1024; i++) busy_plan[i] = 1'b0;
    endtask

    // Runs one program and checks every cycle against a cycle-level model
    // derived from the handshake rules: one FETCH cycle, then instruction k
    // issued on each cycle the core is not busy, then wait for an idle core.
    // Cycle n=0 is the first cycle after run is taken.
    task automatic drive_program(input int len, input int ld_cycle,
                                 input bit ld_with_run, input int ld_a,
                                 input logic [31:0] ld_d, input bit run_noise,
                                 output int exp_cycles, output int exp_issued);
        int exp_idx [1024];
        int eff, n, k, exp_d;
        eff = (len > 256) ? 256 : len;
        for (int i = 0; i < 1024; i++) exp_idx[i] = -1;
        n = 0;
        k = 0;
        if (eff > 0) begin
            n = 1;
            while (k < eff && n < 1000) begin
                exp_idx[n] = k;
                if (!busy_plan[n]) k++;
                n++;
            end
        end
        while (busy_plan[n] && n < 1000) n++;
        exp_d      = n + 1;
        exp_cycles = exp_d;
        exp_issued = eff;

        progLength = len[8:0];
        run        = 1'b1;
        if (ld_with_run) begin
            loadEnable   = 1'b1;
            loadAddr     = ld_a[7:0];
            loadData     = ld_d;
            model_mem[ld_a] = ld_d;
        end
        @(posedge clk); #1;
        run        = 1'b0;
        loadEnable = 1'b0;

        for (int c = 0; c <= exp_d; c++) begin
            coreBusy = busy_plan[c];
            if (c == ld_cycle) begin
                loadEnable = 1'b1;
                loadAddr   = ld_a[7:0];
                loadData   = ld_d;
            end else begin
                loadEnable = 1'b0;
            end
            run = (run_noise && c < exp_d) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            n_checks++;
            if (start !== ((exp_idx[c] >= 0) && !busy_plan[c]))
                $display("FAIL start c=%0d got %b exp %b", c, start,
                         (exp_idx[c] >= 0) && !busy_plan[c]);
            else n_pass++;
            if (exp_idx[c] >= 0) begin
                n_checks++;
                if (instructionIn !== model_mem[exp_idx[c]])
                    $display("FAIL instructionIn c=%0d got %h exp %h", c,
                             instructionIn, model_mem[exp_idx[c]]);
                else n_pass++;
                n_checks++;
                if (programCounter !== 8'(exp_idx[c]))
                    $display("FAIL programCounter c=%0d got %0d exp %0d", c,
                             programCounter, exp_idx[c]);
                else n_pass++;
            end
            n_checks++;
            if (done !== (c == exp_d))
                $display("FAIL done c=%0d got %b exp %b", c, done, c == exp_d);
            else n_pass++;
            @(posedge clk); #1;
        end
        run        = 1'b0;
        loadEnable = 1'b0;
        coreBusy   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; loadEnable = 1'b0; loadAddr = '0; loadData = '0;
        progLength = '0; run = 1'b0; coreBusy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({start, done} !== 2'b00)
            $display("FAIL reset_flags got %b exp 00", {start, done});
        else n_pass++;
        n_checks++;
        if ({programCounter, cycleCount, issueCount, instructionIn} !== '0)
            $display("FAIL reset_values pc=%0d cc=%0d ic=%0d instr=%h exp all 0",
                     programCounter, cycleCount, issueCount, instructionIn);
        else n_pass++;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic load_basic();
        load_word(0, 32'h11); load_word(1, 32'h22);
        load_word(2, 32'h33); load_word(3, 32'h44);
    endtask

    task automatic test_basic();
        int ec, ei;
        load_basic();
        clear_busy();
        drive_program(4, -1, 1'b0, 0, '0, 1'b0, ec, ei);
        n_checks++;
        if (cycleCount !== 32'd6 || ec != 6)
            $display("FAIL basic_cycles got %0d exp 6 (model %0d)", cycleCount, ec);
        else n_pass++;
        n_checks++;
        if (issueCount !== 32'd4)
            $display("FAIL basic_issues got %0d exp 4", issueCount);
        else n_pass++;
    endtask

    task automatic test_busy_stall();
        int ec, ei;
        clear_busy();
        busy_plan[3] = 1'b1; busy_plan[4] = 1'b1; busy_plan[5] = 1'b1;
        drive_program(4, -1, 1'b0, 0, '0, 1'b0, ec, ei);
        n_checks++;
        if (cycleCount !== 32'd9)
            $display("FAIL stall_cycles got %0d exp 9", cycleCount);
        else n_pass++;
        n_checks++;
        if (issueCount !== 32'd4)
            $display("FAIL stall_issues got %0d exp 4", issueCount);
        else n_pass++;
    endtask

    task automatic test_drain_busy();
        int ec, ei;
        clear_busy();
        for (int i = 5; i < 10; i++) busy_plan[i] = 1'b1;
        drive_program(4, -1, 1'b0, 0, '0, 1'b0, ec, ei);
        n_checks++;
        if (cycleCount !== 32'd11)
            $display("FAIL drain_cycles got %0d exp 11", cycleCount);
        else n_pass++;
    endtask

    task automatic test_zero_length();
        int ec, ei;
        clear_busy();
        drive_program(0, -1, 1'b0, 0, '0, 1'b0, ec, ei);
        n_checks++;
        if (cycleCount !== 32'd1)
            $display("FAIL zero_cycles got %0d exp 1", cycleCount);
        else n_pass++;
        n_checks++;
        if (issueCount !== 32'd0)
            $display("FAIL zero_issues got %0d exp 0", issueCount);
        else n_pass++;
    endtask

    task automatic test_load_during_issue();
        int ec, ei;
        clear_busy();
        // Write lands in ISSUE and must be dropped; model memory stays put.
        drive_program(4, 2, 1'b0, 1, 32'hFF, 1'b0, ec, ei);
        drive_program(4, -1, 1'b0, 0, '0, 1'b0, ec, ei);
        n_checks++;
        if (issueCount !== 32'd4)
            $display("FAIL rerun_issues got %0d exp 4", issueCount);
        else n_pass++;
    endtask

    task automatic test_load_with_run();
        int ec, ei;
        clear_busy();
        drive_program(2, -1, 1'b1, 0, 32'hA5A5_0001, 1'b0, ec, ei);
        n_checks++;
        if (issueCount !== 32'd2)
            $display("FAIL loadrun_issues got %0d exp 2", issueCount);
        else n_pass++;
        load_word(0, 32'h11);
    endtask

    task automatic test_reset_mid_issue();
        int ec, ei;
        bit found;
        found = 1'b0;
        progLength = 9'd4;
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        coreBusy = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (programCounter == 8'd2 && start) found = 1'b1;
        end
        n_checks++;
        if (!found) $display("FAIL reach_pc2 got timeout exp pc=2 in ISSUE");
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({start, done} !== 2'b00)
            $display("FAIL async_reset_flags got %b exp 00", {start, done});
        else n_pass++;
        n_checks++;
        if ({programCounter, cycleCount, issueCount} !== '0)
            $display("FAIL async_reset_counters pc=%0d cc=%0d ic=%0d exp 0",
                     programCounter, cycleCount, issueCount);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        clear_busy();
        drive_program(4, -1, 1'b0, 0, '0, 1'b0, ec, ei);
        n_checks++;
        if (cycleCount !== 32'd6 || issueCount !== 32'd4)
            $display("FAIL after_reset_counts cc=%0d ic=%0d exp 6/4",
                     cycleCount, issueCount);
        else n_pass++;
    endtask

    task automatic test_clamp();
        int ec, ei;
        for (int a = 0; a < 256; a++) load_word(a, $urandom);
        clear_busy();
        drive_program(511, -1, 1'b0, 0, '0, 1'b0, ec, ei);
        n_checks++;
        if (issueCount !== 32'd256)
            $display("FAIL clamp_issues got %0d exp 256", issueCount);
        else n_pass++;
        n_checks++;
        if (cycleCount !== 32'd258)
            $display("FAIL clamp_cycles got %0d exp 258", cycleCount);
        else n_pass++;
        n_checks++;
        if (programCounter !== 8'd255)
            $display("FAIL clamp_pc got %0d exp 255", programCounter);
        else n_pass++;
    endtask

    task automatic test_random();
        int ec, ei, len;
        for (int it = 0; it < 8; it++) begin
            len = $urandom_range(0, 24);
            for (int a = 0; a < len; a++) load_word(a, $urandom);
            for (int i = 0; i < 1024; i++) busy_plan[i] = ($urandom_range(0, 99) < 30);
            drive_program(len, -1, 1'b0, 0, '0, 1'b1, ec, ei);
            n_checks++;
            if (cycleCount !== 32'(ec))
                $display("FAIL rand_cycles it=%0d got %0d exp %0d", it, cycleCount, ec);
            else n_pass++;
            n_checks++;
            if (issueCount !== 32'(ei))
                $display("FAIL rand_issues it=%0d got %0d exp %0d", it, issueCount, ei);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy_stall();
        test_drain_busy();
        test_zero_length();
        test_load_during_issue();
        test_load_with_run();
        test_reset_mid_issue();
        test_clamp();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
